// File: rtl/binary_down_counter_par_load_pkg.sv
// Shared types for the loadable down-counter/timer.
// State encoding and default width.
package binary_down_counter_par_load_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } state_t;

endpackage

// File: rtl/binary_down_counter_par_load.sv
// Loadable binary down-counter / interval timer.
// One-shot or auto-reload, borrow cascades to next stage.
module binary_down_counter_par_load
  import binary_down_counter_par_load_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Data_in,
  input  logic             Load,
  input  logic             Count,
  input  logic             Auto_reload,
  output logic [WIDTH-1:0] A_count,
  output logic             B_out,
  output logic             Done,
  output logic             Busy
);

  state_t           state;
  logic [WIDTH-1:0] reload;

  // Terminal count: Load always wins over the borrow.
  assign B_out = Count & ~Load
               & (state == RUN)
               & (A_count == '0);

  assign Busy = (state == RUN);

  // Counter, reload register and mode FSM.
  always_ff @(posedge CLK or negedge Clear) begin
    if (!Clear) begin
      A_count <= '0;
      reload  <= '0;
      Done    <= 1'b0;
      state   <= IDLE;
    end else begin
      Done <= B_out;
      if (Load) begin
        A_count <= Data_in;
        reload  <= Data_in;
        state   <= RUN;
      end else begin
        unique case (state)
          RUN: begin
            if (Count) begin
              if (A_count == '0) begin
                if (Auto_reload) begin
                  A_count <= reload;
                end else begin
                  state <= EXPIRED;
                end
              end else begin
                A_count <= A_count - 1'b1;
              end
            end
          end
          IDLE, EXPIRED: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_binary_down_counter_par_load.sv
// Bench for the down-counter/timer.
// Vector table, corner sequences, random vs model.
module tb_binary_down_counter_par_load;

  localparam int W = 4;

  logic         CLK;
  logic         Clear;
  logic [W-1:0] Data_in;
  logic         Load;
  logic         Count;
  logic         Auto_reload;
  logic [W-1:0] A_count;
  logic         B_out;
  logic         Done;
  logic         Busy;

  binary_down_counter_par_load #(.WIDTH(W)) dut (
    .CLK(CLK),
    .Clear(Clear),
    .Data_in(Data_in),
    .Load(Load),
    .Count(Count),
    .Auto_reload(Auto_reload),
    .A_count(A_count),
    .B_out(B_out),
    .Done(Done),
    .Busy(Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    bit       ld;
    bit [3:0] d;
    bit       c;
    bit       ar;
    int       a;
    bit       b;
    bit       dn;
    bit       bs;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  // Reference model: plain numbers plus two mode flags.
  int m_cnt, m_rld;
  bit m_run, m_exp, m_done;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic model_clear();
    m_cnt  = 0;
    m_rld  = 0;
    m_run  = 0;
    m_exp  = 0;
    m_done = 0;
  endtask

  task automatic add(input bit ld, input int d,
                     input bit c, input bit ar,
                     input int a, input bit b,
                     input bit dn, input bit bs);
    vec_t v;
    v.ld = ld; v.d = d[3:0]; v.c = c; v.ar = ar;
    v.a = a; v.b = b; v.dn = dn; v.bs = bs;
    vecs.push_back(v);
  endtask

  // Drive one cycle; bo = DUT borrow before edge.
  task automatic step(input bit ld, input bit [3:0] d,
                      input bit c, input bit ar,
                      output bit bo, output bit mb);
    @(negedge CLK);
    Load = ld; Data_in = d;
    Count = c; Auto_reload = ar;
    #1;
    bo = B_out;
    mb = c && !ld && m_run && m_cnt == 0;
    m_done = mb;
    if (ld) begin
      m_cnt = d; m_rld = d;
      m_run = 1; m_exp = 0;
    end else if (mb) begin
      if (ar) m_cnt = m_rld;
      else begin m_run = 0; m_exp = 1; end
    end else if (m_run && c) begin
      m_cnt = m_cnt - 1;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    bit bo, mb;
    Clear = 1'b0; Data_in = '0; Load = 1'b0;
    Count = 1'b1; Auto_reload = 1'b0;
    model_clear();

    // Vector table.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 3, 1, 0, 3, 0, 0, 1);
    add(0, 0, 1, 0, 2, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 2, 0, 1, 2, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      add(0, 0, 1, 1, 1, 0, 0, 1);
      add(0, 0, 1, 1, 0, 0, 0, 1);
      add(0, 0, 1, 1, 2, 1, 1, 1);
    end
    add(0, 0, 1, 1, 1, 0, 0, 1);
    add(0, 0, 1, 1, 0, 0, 0, 1);
    add(1, 9, 1, 1, 9, 0, 0, 1);
    add(0, 0, 0, 1, 9, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 5, 0, 0, 5, 0, 0, 1);
    add(0, 0, 1, 0, 4, 0, 0, 1);
    add(0, 0, 0, 0, 4, 0, 0, 1);
    add(0, 0, 0, 0, 4, 0, 0, 1);
    add(0, 0, 1, 0, 3, 0, 0, 1);

    // Reset state while Clear is low.
    #12;
    chk("rst_a", A_count, 0);
    chk("rst_b", B_out, 0);
    chk("rst_done", Done, 0);
    chk("rst_busy", Busy, 0);
    Clear = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].d, vecs[i].c,
           vecs[i].ar, bo, mb);
      chk($sformatf("v%0d_b", i), bo, vecs[i].b);
      chk($sformatf("v%0d_a", i), A_count, vecs[i].a);
      chk($sformatf("v%0d_done", i), Done, vecs[i].dn);
      chk($sformatf("v%0d_busy", i), Busy, vecs[i].bs);
    end

    // Clear mid-count at 6.
    step(1, 9, 0, 0, bo, mb);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, bo, mb);
    chk("pre_clr_a", A_count, 6);
    #2 Clear = 1'b0;
    #1;
    chk("clr_a", A_count, 0);
    chk("clr_busy", Busy, 0);
    chk("clr_done", Done, 0);
    chk("clr_b", B_out, 0);
    model_clear();
    #1 Clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, bo, mb);
      chk("idle_a", A_count, 0);
      chk("idle_busy", Busy, 0);
    end

    // Clear discards a pending Done.
    step(1, 0, 0, 0, bo, mb);
    step(0, 0, 1, 1, bo, mb);
    chk("pend_done", Done, 1);
    #2 Clear = 1'b0;
    #1;
    chk("pend_drop", Done, 0);
    model_clear();
    #1 Clear = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit       ld, c, ar;
      bit [3:0] d;
      ld = ($urandom_range(0, 7) == 0);
      c  = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      d  = 4'($urandom_range(0, 15));
      step(ld, d, c, ar, bo, mb);
      chk("rnd_b", bo, mb);
      chk("rnd_a", A_count, m_cnt);
      chk("rnd_done", Done, m_done);
      chk("rnd_busy", Busy, m_run);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
